regfile_port_arbiter: RTL and testbench



---
 rtl/regfile_arb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 33 +++
 rtl/regfile_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file port arbiter.
// Requester indices fix the meaning of each req/gnt/done bit.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arb_state_e;

    localparam int unsigned DEF_NREQ   = 3;
    localparam int unsigned DEF_DW     = 32;
    localparam int unsigned DEF_RW     = 4;
    localparam int unsigned DEF_RD_LAT = 2;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_BR  = 2;

    // Wide enough for the largest legal read latency (7).
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational one-hot round-robin select over NREQ requesters.
// The search starts at last_winner + 1 and wraps modulo NREQ.
module rr_picker #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_winner,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int unsigned cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 32'(last_winner) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin sequencer for the single register-file port: one transaction at a time,
// with registered strobes, fixed read latency and a one-cycle done pulse to the winner.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RW     = DEF_RW,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*RW-1:0]   req_reg,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 rf_read_en,
    output logic [RW-1:0]        rf_read_reg,
    input  logic [DW-1:0]        rf_read_value,
    output logic                 rf_write_en,
    output logic [RW-1:0]        rf_write_reg,
    output logic [DW-1:0]        rf_write_value
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Counter value loaded on leaving ISSUE; zero means sample on the next edge.
    localparam int unsigned WAIT_LOAD = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rd_en_q, rd_en_d;
    logic [RW-1:0]     rd_reg_q, rd_reg_d;
    logic              wr_en_q, wr_en_d;
    logic [RW-1:0]     wr_reg_q, wr_reg_d;
    logic [DW-1:0]     wr_val_q, wr_val_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     win_q, win_d;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    // A requester still seeing its done pulse is not eligible again yet.
    assign eligible = req & ~done_q;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req         (eligible),
        .last_winner (last_q),
        .gnt         (pick_gnt),
        .idx         (pick_idx),
        .any         (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        rd_en_d  = 1'b0;
        rd_reg_d = rd_reg_q;
        wr_en_d  = 1'b0;
        wr_reg_d = wr_reg_q;
        wr_val_d = wr_val_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt_d  = pick_gnt;
                    win_d  = pick_idx;
                    busy_d = 1'b1;
                    we_d   = req_we[pick_idx];
                    if (req_we[pick_idx]) begin
                        wr_en_d  = 1'b1;
                        wr_reg_d = req_reg[int'(pick_idx) * RW +: RW];
                        wr_val_d = req_wdata[int'(pick_idx) * DW +: DW];
                    end else begin
                        rd_en_d  = 1'b1;
                        rd_reg_d = req_reg[int'(pick_idx) * RW +: RW];
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (we_q) begin
                    done_d  = gnt_q;
                    state_d = StDone;
                end else if (RD_LAT == 1) begin
                    rdata_d = rf_read_value;
                    done_d  = gnt_q;
                    state_d = StDone;
                end else begin
                    cnt_d   = CNT_W'(WAIT_LOAD);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rdata_d = rf_read_value;
                    done_d  = gnt_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                last_d  = win_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            rdata_q  <= '0;
            rd_en_q  <= 1'b0;
            rd_reg_q <= '0;
            wr_en_q  <= 1'b0;
            wr_reg_q <= '0;
            wr_val_q <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            last_q   <= IW'(NREQ - 1);
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
            rd_en_q  <= rd_en_d;
            rd_reg_q <= rd_reg_d;
            wr_en_q  <= wr_en_d;
            wr_reg_q <= wr_reg_d;
            wr_val_q <= wr_val_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign rdata          = rdata_q;
    assign rf_read_en     = rd_en_q;
    assign rf_read_reg    = rd_reg_q;
    assign rf_write_en    = wr_en_q;
    assign rf_write_reg   = wr_reg_q;
    assign rf_write_value = wr_val_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed table, corner sequences, and random traffic
// checked every cycle against a transaction-phase reference model.
module tb_regfile_port_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int RW   = 4;
    localparam int LAT  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0, req_we = '0;
    logic [NREQ*RW-1:0] req_reg = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt, done;
    logic [DW-1:0]     rdata, rf_read_value = '0, rf_write_value;
    logic              busy, rf_read_en, rf_write_en;
    logic [RW-1:0]     rf_read_reg, rf_write_reg;

    // Second instance built with a one-cycle read latency.
    logic [NREQ-1:0]   d1_req = '0, d1_we = '0;
    logic [NREQ*RW-1:0] d1_reg = '0;
    logic [NREQ*DW-1:0] d1_wdata = '0;
    logic [NREQ-1:0]   d1_gnt, d1_done;
    logic [DW-1:0]     d1_rdata, d1_rv = '0, d1_wval;
    logic              d1_busy, d1_rd_en, d1_wr_en;
    logic [RW-1:0]     d1_rd_reg, d1_wr_reg;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_reg(req_reg),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .rf_read_en(rf_read_en), .rf_read_reg(rf_read_reg), .rf_read_value(rf_read_value),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg),
        .rf_write_value(rf_write_value)
    );

    regfile_port_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(d1_req), .req_we(d1_we), .req_reg(d1_reg),
        .req_wdata(d1_wdata), .gnt(d1_gnt), .done(d1_done), .rdata(d1_rdata),
        .busy(d1_busy), .rf_read_en(d1_rd_en), .rf_read_reg(d1_rd_reg),
        .rf_read_value(d1_rv), .rf_write_en(d1_wr_en), .rf_write_reg(d1_wr_reg),
        .rf_write_value(d1_wval)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a transaction is described only by its phase, i.e. the number of
    // cycles since its grant became visible (0 = no transaction in flight).
    int              m_phase = 0;
    int              m_win = 0;
    int              m_last = NREQ - 1;
    bit              m_we = 1'b0;
    logic [RW-1:0]   m_reg = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic [DW-1:0]   m_rdata = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_gnt, e_done;
        bit              e_rd, e_wr, found;
        int              fin, j;
        if (!rst_n) begin
            m_phase = 0;
            m_last  = NREQ - 1;
            m_rdata = '0;
            check("reset_outputs", 128'({gnt, done, busy, rf_read_en, rf_write_en, rf_read_reg,
                  rf_write_reg, rf_write_value, rdata}), 128'(0));
        end else begin
            fin    = m_we ? 2 : LAT + 1;
            e_gnt  = (m_phase != 0) ? NREQ'(1 << m_win) : '0;
            e_done = (m_phase == fin) ? NREQ'(1 << m_win) : '0;
            e_rd   = (m_phase == 1) && !m_we;
            e_wr   = (m_phase == 1) && m_we;
            check("cycle_outputs", 128'({gnt, done, busy, rf_read_en, rf_write_en, rdata}),
                  128'({e_gnt, e_done, (m_phase != 0), e_rd, e_wr, m_rdata}));
            if (e_rd) check("read_index", 128'(rf_read_reg), 128'(m_reg));
            if (e_wr) check("write_fields", 128'({rf_write_reg, rf_write_value}),
                            128'({m_reg, m_wdata}));
            if (m_phase == 0) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    j = (m_last + k) % NREQ;
                    if (!found && req[j]) begin
                        found   = 1'b1;
                        m_win   = j;
                        m_we    = req_we[j];
                        m_reg   = req_reg[j*RW +: RW];
                        m_wdata = req_wdata[j*DW +: DW];
                        m_phase = 1;
                    end
                end
            end else if (m_phase == fin) begin
                m_last  = m_win;
                m_phase = 0;
            end else begin
                if (!m_we && m_phase == LAT) m_rdata = rf_read_value;
                m_phase++;
            end
        end
    end

    typedef struct {
        int          idx;
        bit          we;
        logic [3:0]  rg;
        logic [31:0] wd;
        logic [31:0] rv;
        int          exp_done;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          st_cnt, st_cyc, dn_cnt, dn_cyc, n;
        bit          st_wr;
        logic [3:0]  st_reg;
        logic [31:0] st_val, dn_rdata;
        logic [2:0]  dn_vec;
        logic [2:0]  order[4];
        logic [2:0]  exp_order[4];

        vecs[0] = '{0, 1'b0, 4'd5,  32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
        vecs[1] = '{1, 1'b1, 4'd15, 32'h0000_1000, 32'h5555_5555, 2, 32'hDEAD_BEEF};
        vecs[2] = '{2, 1'b0, 4'd9,  32'h0,         32'h1234_5678, 3, 32'h1234_5678};
        vecs[3] = '{0, 1'b1, 4'd0,  32'hFFFF_FFFF, 32'h0,         2, 32'h1234_5678};
        vecs[4] = '{1, 1'b0, 4'd15, 32'h0,         32'h0,         3, 32'h0};
        exp_order[0] = 3'b001; exp_order[1] = 3'b010;
        exp_order[2] = 3'b100; exp_order[3] = 3'b001;

        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed single transactions from idle.
        for (int v = 0; v < 5; v++) begin
            repeat (2) tick();
            req = '0;
            req[vecs[v].idx] = 1'b1;
            req_we[vecs[v].idx] = vecs[v].we;
            req_reg[vecs[v].idx*RW +: RW] = vecs[v].rg;
            req_wdata[vecs[v].idx*DW +: DW] = vecs[v].wd;
            rf_read_value = vecs[v].rv;
            st_cnt = 0; st_cyc = -1; dn_cnt = 0; dn_cyc = -1;
            st_wr = 0; st_reg = '0; st_val = '0; dn_rdata = '0; dn_vec = '0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (rf_read_en || rf_write_en) begin
                    st_cnt++; st_cyc = c; st_wr = rf_write_en;
                    st_reg = rf_write_en ? rf_write_reg : rf_read_reg;
                    st_val = rf_write_value;
                end
                if (done != 0) begin
                    dn_cnt++; dn_cyc = c; dn_vec = done; dn_rdata = rdata;
                end
                tick();
                if (dn_cnt > 0) req = '0;
            end
            check($sformatf("vec%0d_strobe_cycle", v), 128'(st_cyc), 128'(1));
            check($sformatf("vec%0d_strobe_count", v), 128'(st_cnt), 128'(1));
            check($sformatf("vec%0d_strobe_kind", v), 128'(st_wr), 128'(vecs[v].we));
            check($sformatf("vec%0d_strobe_reg", v), 128'(st_reg), 128'(vecs[v].rg));
            if (vecs[v].we) check($sformatf("vec%0d_wvalue", v), 128'(st_val), 128'(vecs[v].wd));
            check($sformatf("vec%0d_done_cycle", v), 128'(dn_cyc), 128'(vecs[v].exp_done));
            check($sformatf("vec%0d_done_count", v), 128'(dn_cnt), 128'(1));
            check($sformatf("vec%0d_done_vec", v), 128'(dn_vec), 128'(1 << vecs[v].idx));
            check($sformatf("vec%0d_rdata", v), 128'(dn_rdata), 128'(vecs[v].exp_rdata));
        end

        // Round robin from reset with all three requesters held.
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        tick();
        req = 3'b111; req_we = 3'b111;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (done != 0) begin
                order[n] = done;
                n++;
            end
            tick();
        end
        req = '0;
        check("rr_done_count", 128'(n), 128'(4));
        for (int i = 0; i < n; i++) check($sformatf("rr_order%0d", i), 128'(order[i]),
                                          128'(exp_order[i]));

        // Branch read with req dropped during the wait cycle.
        repeat (6) tick();
        req_we = '0; req_reg[2*RW +: RW] = 4'd3;
        req = 3'b100; rf_read_value = 32'hA000_0000;
        dn_cyc = -1; dn_rdata = '0; dn_vec = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done != 0) begin dn_cyc = c; dn_vec = done; dn_rdata = rdata; end
            tick();
            rf_read_value = 32'hA000_0000 + 32'(c + 1);
            if (c + 1 == 2) req[2] = 1'b0;
        end
        check("drop_done_cycle", 128'(dn_cyc), 128'(3));
        check("drop_done_vec", 128'(dn_vec), 128'(3'b100));
        check("drop_rdata", 128'(dn_rdata), 128'(32'hA000_0002));

        // Reset while a read is waiting.
        req = 3'b010;
        repeat (2) tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = '0;
        #1;
        check("async_reset_clears", 128'({gnt, busy, rf_read_en, rf_write_en}), 128'(0));
        dn_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done != 0) dn_cnt++;
        end
        check("reset_no_done", 128'(dn_cnt), 128'(0));
        #2 rst_n = 1'b1;
        tick();
        req = 3'b111; req_we = 3'b111;
        dn_vec = '0;
        for (int c = 0; c < 10 && dn_vec == 0; c++) begin
            @(negedge clk);
            dn_vec = done;
            tick();
        end
        req = '0;
        check("post_reset_winner", 128'(dn_vec), 128'(3'b001));

        // One-cycle-latency build.
        repeat (6) tick();
        d1_we = '0; d1_reg[RW-1:0] = 4'd7; d1_req = 3'b001; d1_rv = 32'hB000_0000;
        st_cyc = -1; dn_cyc = -1; dn_rdata = '0; st_reg = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d1_rd_en) begin st_cyc = c; st_reg = d1_rd_reg; end
            if (d1_done != 0) begin dn_cyc = c; dn_rdata = d1_rdata; end
            tick();
            d1_rv = 32'hB000_0000 + 32'(c + 1);
            if (dn_cyc >= 0) d1_req = '0;
        end
        check("lat1_strobe_cycle", 128'(st_cyc), 128'(1));
        check("lat1_read_reg", 128'(st_reg), 128'(7));
        check("lat1_done_cycle", 128'(dn_cyc), 128'(2));
        check("lat1_rdata", 128'(dn_rdata), 128'(32'hB000_0001));

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0) begin
                    req_we[i] = 1'($urandom);
                    req_reg[i*RW +: RW] = 4'($urandom);
                    req_wdata[i*DW +: DW] = $urandom;
                end
            end
            rf_read_value = $urandom;
            tick();
        end
        req = '0;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
